// File: rtl/taus_checker.sv
// taus_checker -- lock/error monitor for a two-way interleaved Tausworthe stream.
//
// Each accepted word n >= 2 is expected to equal F(word n-2), where
//   F(x) = ((x & CONST) >> SHIFT_R) ^ (((x << SHIFT_L1) ^ x) << SHIFT_L2).
// The compare is registered, so the result of a word accepted at edge k shows
// up on locked / err_pulse / err_count after edge k+1.
//
// Optional feature: define TAUS_CHECKER_STATS_EN to build the err_count and
// word_count statistics counters (and the clear input). Without it both
// outputs are tied to zero and clear is ignored.
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   in_data     received generator word
//   in_valid    in_data valid this cycle (always accepted)
//   clear       synchronous clear of err_count / word_count
//   locked      high while in LOCKED
//   err_pulse   one-cycle pulse per mismatch seen while LOCKED
//   err_count   saturating count of LOCKED mismatches
//   word_count  wrapping count of accepted words
//
// state  | meaning
// FILL0  | history empty, next word becomes h1
// FILL1  | one word held, next word completes history
// SEARCH | comparing, counting consecutive matches toward lock
// LOCKED | locked, counting errors and consecutive misses toward unlock
module taus_checker #(
    parameter logic [31:0] CONST         = 32'hFFFFFFFF,
    parameter logic [3:0]  SHIFT_L1      = 4'hB,
    parameter logic [3:0]  SHIFT_L2      = 4'hB,
    parameter logic [3:0]  SHIFT_R       = 4'hB,
    parameter int          LOCK_THRESH   = 4,
    parameter int          UNLOCK_THRESH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [31:0] word_count
);

    typedef enum logic [1:0] {
        FILL0  = 2'd0,
        FILL1  = 2'd1,
        SEARCH = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_LAST   = 4'(LOCK_THRESH - 1);
    localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_THRESH - 1);

    function automatic logic [31:0] step_f(input logic [31:0] x);
        return ((x & CONST) >> SHIFT_R) ^ (((x << SHIFT_L1) ^ x) << SHIFT_L2);
    endfunction

    state_t      state_q;
    logic [31:0] h1_q;
    logic [31:0] h2_q;
    logic        chk_vld_q;
    logic        chk_match_q;
    logic [3:0]  run_q;
    logic [3:0]  miss_q;
    logic        locked_q;
    logic        err_pulse_q;

    // Stage 1 (accept edge) registers the compare; stage 2 (next edge) acts on
    // it. The two stages never write state_q in the same cycle: a pending
    // compare implies SEARCH/LOCKED, while the fill transitions only fire in
    // FILL0/FILL1, and reset is the only way back to FILL0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL0;
            h1_q        <= '0;
            h2_q        <= '0;
            chk_vld_q   <= 1'b0;
            chk_match_q <= 1'b0;
            run_q       <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            if (chk_vld_q) begin
                case (state_q)
                    SEARCH: begin
                        if (chk_match_q) begin
                            if (run_q == LOCK_LAST) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                run_q    <= '0;
                            end else begin
                                run_q <= run_q + 4'd1;
                            end
                        end else begin
                            run_q <= '0;
                        end
                    end
                    LOCKED: begin
                        if (chk_match_q) begin
                            miss_q <= '0;
                        end else begin
                            err_pulse_q <= 1'b1;
                            if (miss_q == UNLOCK_LAST) begin
                                state_q  <= SEARCH;
                                locked_q <= 1'b0;
                                miss_q   <= '0;
                            end else begin
                                miss_q <= miss_q + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            chk_vld_q <= 1'b0;
            if (in_valid) begin
                h1_q <= in_data;
                h2_q <= h1_q;
                case (state_q)
                    FILL0:   state_q <= FILL1;
                    FILL1:   state_q <= SEARCH;
                    default: begin
                        chk_vld_q   <= 1'b1;
                        chk_match_q <= (in_data == step_f(h2_q));
                    end
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

`ifdef TAUS_CHECKER_STATS_EN
    logic [15:0] err_cnt_q;
    logic [31:0] word_cnt_q;

    // clear beats a coincident error or accepted word.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            if (in_valid) begin
                word_cnt_q <= word_cnt_q + 32'd1;
            end
            if (chk_vld_q && !chk_match_q && (state_q == LOCKED)
                && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign err_count  = err_cnt_q;
    assign word_count = word_cnt_q;
`else
    logic unused_clear;
    assign unused_clear = clear;
    assign err_count    = '0;
    assign word_count   = '0;
`endif

endmodule

// File: tb/tb_taus_checker.sv
module tb_taus_checker;

`ifdef TAUS_CHECKER_STATS_EN
    localparam bit STATS = 1'b1;
    localparam int UT    = 15;
`else
    localparam bit STATS = 1'b0;
    localparam int UT    = 3;
`endif
    localparam int LT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [31:0] word_count;

    taus_checker #(
        .LOCK_THRESH  (LT),
        .UNLOCK_THRESH(UT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;

    // Step function with the default parameters written out as plain arithmetic.
    function automatic logic [31:0] tf(input logic [31:0] x);
        logic [31:0] a;
        logic [31:0] b;
        a = x >> 11;
        b = ((x << 11) ^ x) << 11;
        return a ^ b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit          m_locked, m_pulse;
    logic [15:0] m_err;
    logic [31:0] m_wc;
    int          m_fill, m_run, m_miss;
    logic [31:0] m_h1, m_h2;
    bit          pend, pend_match;

    always @(posedge clk) begin
        if (rst) begin
            m_locked = 0; m_pulse = 0; m_err = '0; m_wc = '0;
            m_fill = 0; m_run = 0; m_miss = 0; m_h1 = '0; m_h2 = '0;
            pend = 0; pend_match = 0;
        end else begin
            m_pulse = 0;
            if (pend) begin
                if (!m_locked) begin
                    m_run = pend_match ? m_run + 1 : 0;
                    if (m_run == LT) begin
                        m_locked = 1; m_run = 0; m_miss = 0;
                    end
                end else if (pend_match) begin
                    m_miss = 0;
                end else begin
                    m_pulse = 1;
                    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                    m_miss = m_miss + 1;
                    if (m_miss == UT) begin
                        m_locked = 0; m_miss = 0; m_run = 0;
                    end
                end
            end
            pend = 0;
            if (in_valid) begin
                m_wc = m_wc + 32'd1;
                if (m_fill < 2) m_fill++;
                else begin
                    pend = 1;
                    pend_match = (in_data == tf(m_h2));
                end
                m_h2 = m_h1;
                m_h1 = in_data;
            end
            if (clear) begin
                m_err = '0;
                m_wc  = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("locked", 32'(locked), 32'(m_locked));
            chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
            chk("err_count", 32'(err_count), STATS ? 32'(m_err) : 32'd0);
            chk("word_count", word_count, STATS ? m_wc : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] g1 = '0, g2 = '0;
    int          gfill = 0;

    task automatic send(input logic [31:0] w, input logic clr);
        in_valid = 1'b1; in_data = w; clear = clr;
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        g2 = g1; g1 = w; gfill++;
    endtask

    task automatic send_good();
        send(tf(g2), 1'b0);
    endtask

    task automatic send_bad();
        send(tf(g2) ^ 32'h1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; clear = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        g1 = '0; g2 = '0; gfill = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        do_reset();
        armed = 1'b1;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err_pulse", 32'(err_pulse), 32'd0);
        chk("rst_word_count", word_count, 32'd0);
        chk("F(1)", tf(32'd1), 32'h00400800);
        chk("F(0)", tf(32'd0), 32'd0);

        // Seeded lock: 1, 0, then true sequence; lock one cycle after 6th word.
        send(32'd1, 1'b0);
        send(32'd0, 1'b0);
        chk("third_word", tf(g2), 32'h00400800);
        repeat (3) send_good();
        chk("lock_after5", 32'(locked), 32'd0);
        send_good();
        chk("lock_at6", 32'(locked), 32'd0);
        idle(1);
        chk("lock_at6+1", 32'(locked), 32'd1);
        chk("wc_after6", word_count, STATS ? 32'd6 : 32'd0);

        // Single corrupted word while locked.
        send_good();
        send_bad();
        send_good();
        chk("single_err_pulse", 32'(err_pulse), 32'd1);
        chk("single_err_count", 32'(err_count), STATS ? 32'd1 : 32'd0);
        send_good();
        chk("single_err_pulse_gone", 32'(err_pulse), 32'd0);
        chk("single_err_locked", 32'(locked), 32'd1);

        // UT consecutive wrong words drop lock, then relock after 4 matches.
        repeat (UT) send_bad();
        chk("unlock_pending", 32'(locked), 32'd1);
        idle(1);
        chk("unlocked", 32'(locked), 32'd0);
        chk("unlock_err_count", 32'(err_count), STATS ? 32'(1 + UT) : 32'd0);
        repeat (4) send_good();
        idle(1);
        chk("relocked", 32'(locked), 32'd1);

        // All-zero stream locks.
        do_reset();
        repeat (6) send(32'd0, 1'b0);
        idle(1);
        chk("zero_lock", 32'(locked), 32'd1);

        // Gapped stream: same lock point in accepted words.
        do_reset();
        send($urandom, 1'b0); idle($urandom_range(1, 5));
        send($urandom, 1'b0); idle($urandom_range(1, 5));
        repeat (3) begin send_good(); idle($urandom_range(1, 5)); end
        chk("gap_lock_after5", 32'(locked), 32'd0);
        send_good(); idle($urandom_range(1, 5));
        chk("gap_lock_at6", 32'(locked), 32'd1);
        chk("gap_wc", word_count, STATS ? 32'd6 : 32'd0);

        // Reset while locked with a word presented.
        rst = 1'b1; in_valid = 1'b1; in_data = tf(g2);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        g1 = '0; g2 = '0; gfill = 0;
        chk("rst_locked_drop", 32'(locked), 32'd0);
        chk("rst_locked_wc", word_count, 32'd0);
        send(32'h1234_5678, 1'b0);
        send(32'h9abc_def0, 1'b0);
        send(32'h0000_0000, 1'b0);
        idle(1);
        chk("postrst_no_err", 32'(err_pulse), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic clr;
            logic [31:0] w;
            r = $urandom_range(0, 999);
            if (r < 4) begin
                do_reset();
                continue;
            end
            if ($urandom_range(0, 3) != 0) idle($urandom_range(0, 5));
            clr = ($urandom_range(0, 99) < 3);
            if (gfill < 2) w = $urandom;
            else if ($urandom_range(0, 99) < 15) w = tf(g2) ^ ($urandom | 32'h1);
            else w = tf(g2);
            send(w, clr);
        end

`ifdef TAUS_CHECKER_STATS_EN
        // Saturate err_count while staying locked, then clear.
        do_reset();
        send(32'hdead_beef, 1'b0);
        send(32'h0bad_f00d, 1'b0);
        repeat (LT) send_good();
        idle(1);
        chk("sat_locked", 32'(locked), 32'd1);
        for (int k = 0; k < 4682; k++) begin
            repeat (UT - 1) send_bad();
            send_good();
        end
        send_bad();
        send_good();
        chk("sat_err_count", 32'(err_count), 32'h0000FFFF);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("sat_clear", 32'(err_count), 32'd0);
`endif

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
